// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the error-response state type used by the
// block RAM controller.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Two-cycle ERROR response: ERR1 stalls the bus, ERR2 releases it.
  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_e;

endpackage

// File: rtl/ahb_byte_mask.sv
// Decodes HSIZE and the low address bits into RAM byte lanes and flags
// sizes or alignments the 32-bit RAM cannot serve.
module ahb_byte_mask
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       legal
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case can leave it unassigned and infer a latch.
    mask  = 4'b0000;
    legal = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        legal = 1'b1;
        mask  = 4'b0001 << addr_lo;
      end
      HSIZE_HALF: begin
        legal = ~addr_lo[0];
        mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        legal = (addr_lo == 2'b00);
        mask  = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// Zero-wait AHB-Lite slave in front of a dual-port block RAM (A = write,
// B = registered read), with write-to-read forwarding and ERROR responses.
module ahb_bram_ctrl
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [31:0]           bram_dina,
  output logic [3:0]            bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [31:0]           bram_doutb
);

  err_state_e            state_q, state_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  fwd_q, fwd_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]            wr_mask_q, wr_mask_d;
  logic [3:0]            fwd_mask_q, fwd_mask_d;
  logic [31:0]           fwd_data_q, fwd_data_d;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [3:0]            acc_mask;
  logic                  acc_legal;
  logic                  trans_active;
  logic                  accept;
  logic                  unused_haddr;

  // Upper address bits alias onto the RAM; they are intentionally ignored.
  assign word_addr    = HADDR[ADDR_WIDTH+1:2];
  assign unused_haddr = ^HADDR[31:ADDR_WIDTH+2];

  assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  // ERR1 holds the bus, so nothing new can be taken in that cycle.
  assign accept = HSEL & HREADY & trans_active & (state_q != ST_ERR1);

  ahb_byte_mask u_byte_mask (
    .hsize   (HSIZE),
    .addr_lo (HADDR[1:0]),
    .mask    (acc_mask),
    .legal   (acc_legal)
  );

  always_comb begin
    state_d    = state_q;
    wr_pend_d  = 1'b0;
    rd_pend_d  = 1'b0;
    fwd_d      = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_mask_d  = wr_mask_q;
    fwd_mask_d = fwd_mask_q;
    fwd_data_d = fwd_data_q;

    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_OKAY;
        if (accept) begin
          if (!acc_legal) begin
            state_d = ST_ERR1;
          end else if (HWRITE) begin
            wr_pend_d = 1'b1;
            wr_addr_d = word_addr;
            wr_mask_d = acc_mask;
          end else begin
            rd_pend_d = 1'b1;
            // The RAM reads the old word while port A commits this write,
            // so the in-flight bytes are patched into the read data.
            if (wr_pend_q && (word_addr == wr_addr_q)) begin
              fwd_d      = 1'b1;
              fwd_data_d = HWDATA;
              fwd_mask_d = wr_mask_q;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_OKAY;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      fwd_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_mask_q  <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its pre-edge
      // inputs, independent of statement order.
      state_q    <= state_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      fwd_q      <= fwd_d;
      wr_addr_q  <= wr_addr_d;
      wr_mask_q  <= wr_mask_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign HREADYOUT  = (state_q != ST_ERR1);
  assign HRESP      = (state_q == ST_OKAY) ? HRESP_OKAY : HRESP_ERROR;

  assign bram_addra = wr_addr_q;
  assign bram_dina  = HWDATA;
  assign bram_wea   = wr_pend_q ? wr_mask_q : 4'b0000;
  assign bram_addrb = word_addr;

  always_comb begin
    HRDATA = '0;
    if (rd_pend_q) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = (fwd_q && fwd_mask_q[i]) ? fwd_data_q[8*i +: 8]
                                                    : bram_doutb[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed bench for ahb_bram_ctrl with a behavioural dual-port RAM
// (write-first on port A, registered read-old on port B).
module tb_ahb_bram_ctrl;
  import ahb_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [11:0] bram_addra;
  logic [31:0] bram_dina;
  logic [3:0]  bram_wea;
  logic [11:0] bram_addrb;
  logic [31:0] bram_doutb;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:4095];

  // Single-slave bus: the interconnect returns this slave's ready.
  assign HREADY = HREADYOUT;

  ahb_bram_ctrl #(.ADDR_WIDTH(12)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HSIZE      (HSIZE),
    .HWRITE     (HWRITE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_wea   (bram_wea),
    .bram_addrb (bram_addrb),
    .bram_doutb (bram_doutb)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    for (int i = 0; i < 4; i++)
      if (bram_wea[i]) mem[bram_addra][8*i +: 8] <= bram_dina[8*i +: 8];
    bram_doutb <= mem[bram_addrb];
  end

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic sel, input logic [1:0] trans,
                            input logic [31:0] addr, input logic [2:0] size,
                            input logic wr);
    HSEL   = sel;
    HTRANS = trans;
    HADDR  = addr;
    HSIZE  = size;
    HWRITE = wr;
  endtask

  task automatic bus_idle();
    addr_phase(1'b1, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    bus_idle();
    HSEL   = 1'b0;
    HWDATA = 32'h0;
    repeat (2) @(posedge HCLK);
    #1;
    n_assert++;
    if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: got %b expected 1", HREADYOUT); end
    n_assert++;
    if (HRESP !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: got %b expected 0", HRESP); end
    n_assert++;
    if (bram_wea !== 4'h0) begin n_fail++; $display("FAIL reset_wea: got %h expected 0", bram_wea); end
    n_assert++;
    if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h expected 0", HRDATA); end
    HRESETn = 1'b1;
    next_cycle();
  endtask

  task automatic test_word_write_read();
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b1);
    next_cycle();
    HWDATA = 32'hDEADBEEF;
    bus_idle();
    @(negedge HCLK);
    n_assert++;
    if (bram_wea !== 4'hF) begin n_fail++; $display("FAIL word_wr_wea: got %h expected f", bram_wea); end
    n_assert++;
    if (bram_addra !== 12'd4) begin n_fail++; $display("FAIL word_wr_addra: got %h expected 004", bram_addra); end
    n_assert++;
    if (bram_dina !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_wr_dina: got %h expected deadbeef", bram_dina); end
    n_assert++;
    if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL word_wr_ready: got %b expected 1", HREADYOUT); end
    next_cycle();
    @(negedge HCLK);
    n_assert++;
    if (bram_wea !== 4'h0) begin n_fail++; $display("FAIL word_idle_wea: got %h expected 0", bram_wea); end
    next_cycle();
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0);
    @(negedge HCLK);
    n_assert++;
    if (bram_addrb !== 12'd4) begin n_fail++; $display("FAIL word_rd_addrb: got %h expected 004", bram_addrb); end
    next_cycle();
    bus_idle();
    @(negedge HCLK);
    n_assert++;
    if (HRDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_rd_data: got %h expected deadbeef", HRDATA); end
    n_assert++;
    if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL word_rd_resp: got resp=%b ready=%b expected 0/1", HRESP, HREADYOUT); end
    next_cycle();
    @(negedge HCLK);
    n_assert++;
    if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL word_rd_idle_data: got %h expected 0", HRDATA); end
    next_cycle();
  endtask

  task automatic test_byte_writes();
    logic [7:0] bval [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h20, HSIZE_BYTE, 1'b1);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      HWDATA = {24'h0, bval[i]} << (8 * i);
      if (i < 3) addr_phase(1'b1, HTRANS_NONSEQ, 32'h21 + i, HSIZE_BYTE, 1'b1);
      else       addr_phase(1'b1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b0);
      @(negedge HCLK);
      n_assert++;
      if (bram_wea !== (4'b0001 << i)) begin n_fail++; $display("FAIL byte_wr_wea[%0d]: got %h expected %h", i, bram_wea, 4'b0001 << i); end
      next_cycle();
    end
    bus_idle();
    @(negedge HCLK);
    n_assert++;
    if (HRDATA !== 32'h44332211) begin n_fail++; $display("FAIL byte_rd_data: got %h expected 44332211", HRDATA); end
    next_cycle();
  endtask

  task automatic test_raw_forward();
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h30, HSIZE_WORD, 1'b1);
    next_cycle();
    HWDATA = 32'hAAAAAAAA;
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h32, HSIZE_HALF, 1'b1);
    @(negedge HCLK);
    n_assert++;
    if (bram_wea !== 4'hF) begin n_fail++; $display("FAIL waw_first_wea: got %h expected f", bram_wea); end
    next_cycle();
    HWDATA = 32'h55550000;
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h30, HSIZE_WORD, 1'b0);
    @(negedge HCLK);
    n_assert++;
    if (bram_wea !== 4'hC || bram_addra !== 12'h00C) begin n_fail++; $display("FAIL waw_half_wea: got wea=%h addra=%h expected c/00c", bram_wea, bram_addra); end
    next_cycle();
    bus_idle();
    @(negedge HCLK);
    n_assert++;
    if (HRDATA !== 32'h5555AAAA) begin n_fail++; $display("FAIL raw_fwd_data: got %h expected 5555aaaa", HRDATA); end
    n_assert++;
    if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL raw_fwd_ready: got %b expected 1", HREADYOUT); end
    next_cycle();
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h30, HSIZE_WORD, 1'b0);
    next_cycle();
    bus_idle();
    @(negedge HCLK);
    n_assert++;
    if (HRDATA !== 32'h5555AAAA) begin n_fail++; $display("FAIL raw_ram_data: got %h expected 5555aaaa", HRDATA); end
    next_cycle();
  endtask

  task automatic test_no_forward();
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h44, HSIZE_WORD, 1'b1);
    next_cycle();
    HWDATA = 32'h12345678;
    bus_idle();
    next_cycle();
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 1'b1);
    next_cycle();
    HWDATA = 32'hCAFEF00D;
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h44, HSIZE_WORD, 1'b0);
    @(negedge HCLK);
    n_assert++;
    if (bram_addrb !== 12'h011) begin n_fail++; $display("FAIL nofwd_addrb: got %h expected 011", bram_addrb); end
    next_cycle();
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 1'b0);
    @(negedge HCLK);
    n_assert++;
    if (HRDATA !== 32'h12345678) begin n_fail++; $display("FAIL nofwd_data: got %h expected 12345678", HRDATA); end
    next_cycle();
    bus_idle();
    @(negedge HCLK);
    n_assert++;
    if (HRDATA !== 32'hCAFEF00D) begin n_fail++; $display("FAIL nofwd_rar_data: got %h expected cafef00d", HRDATA); end
    next_cycle();
  endtask

  task automatic test_error();
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h50, HSIZE_WORD, 1'b1);
    next_cycle();
    HWDATA = 32'h0BADF00D;
    bus_idle();
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) addr_phase(1'b1, HTRANS_NONSEQ, 32'h50, 3'd3, 1'b1);
      else        addr_phase(1'b1, HTRANS_NONSEQ, 32'h52, HSIZE_WORD, 1'b1);
      next_cycle();
      HWDATA = 32'hFFFFFFFF;
      bus_idle();
      @(negedge HCLK);
      n_assert++;
      if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin n_fail++; $display("FAIL err%0d_cycle1: got ready=%b resp=%b expected 0/1", k, HREADYOUT, HRESP); end
      n_assert++;
      if (bram_wea !== 4'h0) begin n_fail++; $display("FAIL err%0d_wea1: got %h expected 0", k, bram_wea); end
      next_cycle();
      if (k == 1) addr_phase(1'b1, HTRANS_NONSEQ, 32'h50, HSIZE_WORD, 1'b0);
      @(negedge HCLK);
      n_assert++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b1) begin n_fail++; $display("FAIL err%0d_cycle2: got ready=%b resp=%b expected 1/1", k, HREADYOUT, HRESP); end
      n_assert++;
      if (bram_wea !== 4'h0) begin n_fail++; $display("FAIL err%0d_wea2: got %h expected 0", k, bram_wea); end
      next_cycle();
      bus_idle();
    end
    @(negedge HCLK);
    n_assert++;
    if (HRDATA !== 32'h0BADF00D) begin n_fail++; $display("FAIL err_ram_intact: got %h expected 0badf00d", HRDATA); end
    n_assert++;
    if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL err_recover: got resp=%b ready=%b expected 0/1", HRESP, HREADYOUT); end
    next_cycle();
  endtask

  task automatic test_hsel_and_reset();
    addr_phase(1'b0, HTRANS_NONSEQ, 32'h60, HSIZE_WORD, 1'b1);
    next_cycle();
    HWDATA = 32'h77777777;
    bus_idle();
    @(negedge HCLK);
    n_assert++;
    if (bram_wea !== 4'h0) begin n_fail++; $display("FAIL hsel0_wea: got %h expected 0", bram_wea); end
    next_cycle();
    addr_phase(1'b1, HTRANS_NONSEQ, 32'h60, HSIZE_WORD, 1'b1);
    next_cycle();
    HWDATA = 32'h99999999;
    bus_idle();
    @(negedge HCLK);
    n_assert++;
    if (bram_wea !== 4'hF) begin n_fail++; $display("FAIL rst_pre_wea: got %h expected f", bram_wea); end
    #2;
    HRESETn = 1'b0;
    #1;
    n_assert++;
    if (bram_wea !== 4'h0) begin n_fail++; $display("FAIL rst_async_wea: got %h expected 0", bram_wea); end
    next_cycle();
    HRESETn = 1'b1;
    next_cycle();
    @(negedge HCLK);
    n_assert++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_fail++; $display("FAIL rst_after_resp: got ready=%b resp=%b expected 1/0", HREADYOUT, HRESP); end
    n_assert++;
    if (bram_wea !== 4'h0 || HRDATA !== 32'h0) begin n_fail++; $display("FAIL rst_after_state: got wea=%h hrdata=%h expected 0/0", bram_wea, HRDATA); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_word_write_read();
    test_byte_writes();
    test_raw_forward();
    test_no_forward();
    test_error();
    test_hsel_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_bram_ctrl.md
Name: ahb_bram_ctrl

Overview:
- AHB-Lite slave that fronts the dual-port 32-bit block RAM (port A write, port B read) in the Cortex-M0 SoC.
- Converts AHB address/data-phase transactions into RAM port signals: `bram_addra`/`bram_dina`/`bram_wea` for writes, `bram_addrb` for reads, and returns `bram_doutb` on `HRDATA`.
- Zero-wait-state for legal accesses.
- Forwards a write still in its data phase into an immediately following read of the same word.
- Issues a two-cycle ERROR response for illegal size or alignment.

Parameters:
- ADDR_WIDTH, 12, RAM word-address width; RAM depth is 2**ADDR_WIDTH 32-bit words; byte address bits [ADDR_WIDTH+1:2] are used.

Ports:
- HCLK  in  1  system clock; all state on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type; bit1 = NONSEQ/SEQ
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word; others illegal
- HWRITE  in  1  1 = write
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-level ready (address phase accepted when high)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  32  read data
- bram_addra  out  ADDR_WIDTH  RAM write word address
- bram_dina  out  32  RAM write data
- bram_wea  out  4  RAM byte write enables
- bram_addrb  out  ADDR_WIDTH  RAM read word address
- bram_doutb  in  32  RAM registered read data (1-cycle latency)

Behaviour:
- Interface: one clock, HCLK; HRESETn asynchronous, active-low.
- Reset values:
  - HREADYOUT=1, HRESP=0.
  - Write-pending flag=0, read-pending flag=0, forward flag=0.
  - FSM=OKAY; all captured address/mask registers=0.
  - bram_wea=0; HRDATA=0.
- Transfer accept: a transfer is accepted when HSEL & HREADY & HTRANS[1].
- Legality check at accept: HSIZE<=2, halfword HADDR[0]=0, word HADDR[1:0]=0. Otherwise the access is illegal.
- Byte mask (legal accesses):
  - byte: 1<<HADDR[1:0]
  - halfword: 4'b0011 or 4'b1100 by HADDR[1]
  - word: 4'b1111
- Legal write:
  - Register wr_pend=1, word address, mask.
  - In the data phase, drive bram_addra=reg addr, bram_dina=HWDATA, bram_wea=mask (combinational from registers).
  - RAM commits at the end of the data phase.
  - bram_wea=0 whenever wr_pend=0.
- Legal read:
  - bram_addrb=HADDR[ADDR_WIDTH+1:2] combinationally during the address phase.
  - rd_pend=1; HRDATA=bram_doutb in the next cycle (data phase).
  - HRDATA=0 when rd_pend=0.
- RAW forwarding: if a read is accepted while wr_pend=1 with the same word address:
  - Capture HWDATA and the write mask that cycle; set fwd=1.
  - In the read data phase, HRDATA byte i = fwd_mask[i] ? fwd_data[i] : bram_doutb[i].
  - Read-after-read and different-address cases pass through unmodified.
- Write-after-write back-to-back: each write gets its own data-phase cycle; no stall.
- Error FSM:
  - OKAY: an illegal access accepted -> ERR1, with no RAM enable asserted.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 -> OKAY.
  - In ERR1/ERR2, pending flags are cleared.
  - A transfer presented during ERR2 with HREADY=1 is accepted normally.
- IDLE/BUSY (HTRANS[1]=0) or HSEL=0: no new pending state; an already-pending data phase still completes.
- Address out of range: upper address bits are ignored (aliasing); no error.
- Reset mid-operation: a pending write is dropped (no RAM enable after reset asserts); the FSM returns to OKAY.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ).
  - HSIZE encodings (BYTE, HALF, WORD).
  - HRESP codes.
  - Error FSM state typedef (OKAY, ERR1, ERR2).
- One natural sub-module: ahb_byte_mask (combinational HSIZE/HADDR[1:0] -> 4-bit mask + legal flag).
- The RAM is instantiated at SoC level, not inside this block.

Test Plan:
- Word write 0xDEADBEEF to 0x0000_0010, then two IDLE cycles, then a read of 0x10 -> bram_wea=4'hF and bram_addra=4 in the data phase; HRDATA=0xDEADBEEF, HRESP=0, no wait states.
- Byte writes 0x11, 0x22, 0x33, 0x44 to 0x20..0x23, then a word read of 0x20 -> wea seen as 1, 2, 4, 8; HRDATA=0x44332211.
- RAM word 0x30 = 0xAAAAAAAA; halfword write 0x5555 to 0x32, immediately followed by a word read of 0x30 -> HRDATA=0x5555AAAA in the next cycle, zero wait.
- Back-to-back write to 0x40 then read of 0x44 -> no forwarding; HRDATA = RAM content of word 0x11.
- HSIZE=3 at 0x50, and separately a word access at 0x52 -> HREADYOUT 0 then 1, HRESP=1 for both cycles, bram_wea stays 0, RAM unchanged.
- HSEL=0 with HTRANS=NONSEQ and HWRITE=1 -> no wea. Assert HRESETn=0 during a write data phase -> bram_wea drops to 0 asynchronously; HREADYOUT=1 and HRESP=0 after reset.
